memblock_reader: RTL and testbench
==================================

MEMBLOCK_READER -- requirements
Module: memblock_reader

Interface
REQ-001 Parameter WIDTH, default 1, data word width in bits; it SHALL match the attached memory.
REQ-002 Parameter DEPTH, default 1, memory word count; AW = $clog2(DEPTH), CW = $clog2(DEPTH)+1.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 start  in  1  command strobe, sampled only in IDLE.
REQ-006 base_addr  in  AW  first word address of the burst.
REQ-007 count  in  CW  number of words to stream, 0..DEPTH.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 rd_addr0  out  AW  address to the memory read port; the memory returns data combinationally.
REQ-011 rd_dout0  in  WIDTH  read data from the memory, valid in the same cycle as rd_addr0.
REQ-012 out_valid  out  1  stream beat valid.
REQ-013 out_ready  in  1  stream sink ready.
REQ-014 out_data  out  WIDTH  stream beat data.
REQ-015 out_last  out  1  marks the final beat of the burst.

Function
REQ-016 The FSM SHALL have three states, IDLE, STREAM and DONE, and SHALL leave IDLE only on start=1.
- IDLE with start=1 and count!=0: latch addr=base_addr and rem=count, then go to STREAM.
- IDLE with start=1 and count=0: go directly to DONE, with no beats.
REQ-017 rd_addr0 SHALL always equal the internal addr register.
REQ-018 In STREAM, a load occurs when rem!=0 and (out_valid=0 or out_ready=1). On each load the block SHALL do all of the following:
- out_data <= rd_dout0
- out_valid <= 1
- out_last <= (rem==1)
- rem <= rem-1
- addr advances by one.
REQ-019 Address wrap: addr==DEPTH-1 SHALL advance to 0. This applies to any DEPTH, not only powers of two.
REQ-020 A beat completes when out_valid=1 and out_ready=1. On completion with no load in the same cycle, out_valid SHALL clear.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_last and addr SHALL hold stable.
REQ-022 When the out_last beat completes, the FSM SHALL go from STREAM to DONE. In DONE, done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-023 Latency: start accepted at edge T SHALL give out_valid=1 with data mem[base_addr] after edge T+1.
- With out_ready held at 1, one beat SHALL complete per cycle, with no bubbles.
REQ-024 start SHALL be ignored in STREAM and DONE; the burst in flight is unaffected.
REQ-025 Data SHALL be captured at load time; later memory writes to an already-loaded address SHALL NOT alter the beat.
REQ-026 count values greater than DEPTH SHALL be treated as DEPTH (saturate).

Reset
REQ-027 On rst=1 (asynchronous, mid-burst included), the block SHALL immediately force all of the following:
- state=IDLE
- addr=0, rem=0
- out_valid=0, out_last=0, out_data=0
- done=0, busy=0
REQ-028 After rst deasserts, the block SHALL accept a new start on the first following edge.

Structure
REQ-029 A shared package memblock_pkg SHALL hold the state enum (IDLE, STREAM, DONE) and the wrap-increment function.
REQ-030 The output register and handshake logic SHALL be one sub-module, memblock_out_stage, parameterised by WIDTH. The FSM and counters stay in memblock_reader.

Verification
All scenarios use a memblock_reader paired with a WIDTH=8, DEPTH=8 memory preloaded with mem[i]=8'hA0+i.
REQ-031 Basic burst: base_addr=2, count=3, out_ready=1.
- Beats A2, A3, A4 on consecutive cycles, with out_last only on A4.
- done pulses once, one cycle after A4 completes.
REQ-032 Wrap: base_addr=6, count=4.
- Beats A6, A7, A0, A1.
- rd_addr0 sequence 6, 7, 0, 1.
REQ-033 Backpressure: base_addr=0, count=3, out_ready toggled 1,0,0,1,1.
- Beats A0, A1, A2 in order, with no loss or duplication.
- out_data stable throughout every stalled cycle.
REQ-034 Zero length: count=0.
- No out_valid.
- busy high for one cycle, done pulses once.
- start issued during DONE is ignored.
REQ-035 Reset mid-burst: base_addr=0, count=8, rst asserted after the 3rd beat.
- Outputs zero immediately, state IDLE.
- A new burst with base_addr=5, count=1 then yields a single beat A5 with out_last=1.

Source files
------------

// File: rtl/memblock_pkg.sv
// memblock_pkg
// Shared definitions for the memory block reader: the controller state
// encoding and the address wrap-increment helper.
package memblock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Next address after addr in a memory of 'depth' words. The last word
    // wraps to 0, so non-power-of-two depths wrap correctly. The >= also
    // covers depth=1, where the only address is 0.
    function automatic logic [31:0] wrap_inc(input logic [31:0] addr,
                                             input logic [31:0] depth);
        wrap_inc = (addr >= depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/memblock_out_stage.sv
// memblock_out_stage
// Output register and valid/ready handshake for the reader's stream port.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - capture din/last_in into the output register this cycle
//   din        - word to capture (memory read data)
//   last_in    - final-beat flag to capture with din
//   out_ready  - sink ready
//   out_valid  - beat valid
//   out_data   - beat data
//   out_last   - final beat of the burst
module memblock_out_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             last_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= din;
            out_last  <= last_in;
        end else if (out_valid && out_ready) begin
            // Data and last are left as-is; they are don't-care once valid drops.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/memblock_reader.sv
// memblock_reader
// Streams a burst of words from a combinational-read memory onto a
// valid/ready port, starting at base_addr and wrapping at DEPTH.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - command strobe, only honoured in IDLE
//   base_addr  - first word address of the burst
//   count      - words to stream (0..DEPTH, larger values saturate)
//   busy       - high whenever not IDLE
//   done       - one-cycle completion pulse
//   rd_addr0   - memory read address
//   rd_dout0   - memory read data (same cycle as rd_addr0)
//   out_valid, out_ready, out_data, out_last - output stream
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | loading words into the output stage until the last beat completes
// DONE   | single-cycle done pulse, then back to IDLE
module memblock_reader
    import memblock_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [CW-1:0]    count,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    rd_addr0,
    input  logic [WIDTH-1:0] rd_dout0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] addr;
    logic [CW-1:0] rem;
    logic [CW-1:0] count_sat;
    logic          load;
    logic          last_beat_done;

    assign count_sat      = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
    assign rd_addr0       = addr;
    // A new word may enter the output stage when it is empty or draining.
    assign load           = (state == STREAM) && (rem != '0) && (!out_valid || out_ready);
    assign last_beat_done = out_valid && out_ready && out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            rem   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start && count_sat != '0) begin
                addr <= base_addr;
                rem  <= count_sat;
            end else if (load) begin
                addr <= AW'(wrap_inc(32'(addr), 32'(DEPTH)));
                rem  <= rem - CW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start)
                    state_next = (count_sat == '0) ? DONE : STREAM;
            end
            STREAM: begin
                if (last_beat_done)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    memblock_out_stage #(
        .WIDTH(WIDTH)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .din       (rd_dout0),
        .last_in   (rem == CW'(1)),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_memblock_reader.sv
// tb_memblock_reader
// Directed bench for memblock_reader with WIDTH=8, DEPTH=8 and a memory
// preloaded with mem[i] = 8'hA0 + i. Inputs are driven and outputs sampled
// on the falling clock edge.
module tb_memblock_reader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] base_addr;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [2:0] rd_addr0;
    logic [7:0] rd_dout0;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    logic [7:0] mem [0:7];
    int errors = 0;
    int checks = 0;

    assign rd_dout0 = mem[rd_addr0];

    memblock_reader #(
        .WIDTH(8),
        .DEPTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rd_addr0  (rd_addr0),
        .rd_dout0  (rd_dout0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_data !== 8'h00 || rd_addr0 !== 3'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b valid=%b last=%b data=%h addr=%0d expected all zero",
                     busy, done, out_valid, out_last, out_data, rd_addr0);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] exp_data [3] = '{8'hA2, 8'hA3, 8'hA4};
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = 3'd2; count = 4'd3;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency valid=%b busy=%b expected valid=0 busy=1", out_valid, busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data[i] || out_last !== (i == 2) || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d valid=%b data=%h last=%b done=%b expected valid=1 data=%h last=%b done=0",
                         i, out_valid, out_data, out_last, done, exp_data[i], (i == 2));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_done done=%b valid=%b busy=%b expected done=1 valid=0 busy=1", done, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_data [4] = '{8'hA6, 8'hA7, 8'hA0, 8'hA1};
        logic [2:0] exp_addr [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = 3'd6; count = 4'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 4) begin
                checks++;
                if (rd_addr0 !== exp_addr[i]) begin
                    errors++;
                    $display("FAIL wrap_addr%0d rd_addr0=%0d expected %0d", i, rd_addr0, exp_addr[i]);
                end
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_data[i-1] || out_last !== (i == 4)) begin
                    errors++;
                    $display("FAIL wrap_beat%0d valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                             i - 1, out_valid, out_data, out_last, exp_data[i-1], (i == 4));
                end
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done done=%b valid=%b expected done=1 valid=0", done, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_data [3] = '{8'hA0, 8'hA1, 8'hA2};
        bit         pat [5]      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int         nb           = 0;
        int         j            = 1;
        bit         stalled      = 1'b0;
        bit         seen_done    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = 3'd0; count = 4'd3;
        @(negedge clk);
        start = 1'b0;
        out_ready = pat[0];
        for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_data[nb]) begin
                    errors++;
                    $display("FAIL bp_stall_hold cyc=%0d valid=%b data=%h expected valid=1 data=%h",
                             cyc, out_valid, out_data, exp_data[nb]);
                end
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
            end else begin
                out_ready = (j < 5) ? pat[j] : 1'b1;
                j++;
                // Overwrite a word that is already sitting in the output register.
                if (cyc == 0) mem[0] = 8'h55;
                if (out_valid === 1'b1 && out_ready) begin
                    checks++;
                    if (nb >= 3) begin
                        errors++;
                        $display("FAIL bp_extra_beat data=%h expected no beat", out_data);
                    end else if (out_data !== exp_data[nb] || out_last !== (nb == 2)) begin
                        errors++;
                        $display("FAIL bp_beat%0d data=%h last=%b expected data=%h last=%b",
                                 nb, out_data, out_last, exp_data[nb], (nb == 2));
                    end
                    nb++;
                    stalled = 1'b0;
                end else begin
                    stalled = (out_valid === 1'b1) && nb < 3;
                end
            end
        end
        checks++;
        if (!seen_done || nb != 3) begin
            errors++;
            $display("FAIL bp_complete beats=%0d done_seen=%0d expected beats=3 done_seen=1", nb, seen_done);
        end
        mem[0] = 8'hA0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero();
        @(negedge clk);
        start = 1'b1; base_addr = 3'd4; count = 4'd0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done busy=%b done=%b valid=%b expected 1 1 0", busy, done, out_valid);
        end
        // start held high through DONE must not launch a burst
        start = 1'b1; base_addr = 3'd3; count = 4'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle busy=%b done=%b valid=%b expected 0 0 0", busy, done, out_valid);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_start_ignored busy=%b valid=%b expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_data [8] = '{8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = 3'd4; count = 4'd15;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data[i] || out_last !== (i == 7)) begin
                errors++;
                $display("FAIL sat_beat%0d valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                         i, out_valid, out_data, out_last, exp_data[i], (i == 7));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_done done=%b valid=%b expected done=1 valid=0", done, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = 3'd0; count = 4'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA2) begin
            errors++;
            $display("FAIL rst_third_beat valid=%b data=%h expected valid=1 data=a2", out_valid, out_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_data !== 8'h00 || rd_addr0 !== 3'd0) begin
            errors++;
            $display("FAIL rst_async busy=%b done=%b valid=%b last=%b data=%h addr=%0d expected all zero",
                     busy, done, out_valid, out_last, out_data, rd_addr0);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; base_addr = 3'd5; count = 4'd1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart_accept busy=%b valid=%b expected busy=1 valid=0", busy, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart_beat valid=%b data=%h last=%b expected valid=1 data=a5 last=1",
                     out_valid, out_data, out_last);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart_done done=%b valid=%b expected done=1 valid=0", done, out_valid);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart_idle busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 3'd0;
        count     = 4'd0;
        out_ready = 1'b0;

        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero();
        test_saturate();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
